// File: rtl/sprite_select_scheduler.sv
// sprite_select_scheduler: per-line object scan plus per-pixel sprite/tile priority resolve.
// Optional feature macro: FRIGHTENED_GHOST_EN (ghosts with their ghost_fright bit set show code 4).
module sprite_select_scheduler #(
  parameter int unsigned NUM_OBJ      = 6,
  parameter int unsigned MAX_LINE_OBJ = 4,
  parameter int unsigned SPR_BITS     = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    line_start,
  input  logic [9:0]              next_y,
  input  logic                    pixel_valid,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [10*NUM_OBJ-1:0]   obj_x_flat,
  input  logic [10*NUM_OBJ-1:0]   obj_y_flat,
  input  logic [NUM_OBJ-1:0]      obj_en,
  input  logic [3:0]              ghost_fright,
  output logic [9:0]              tile_addr,
  input  logic [2:0]              tile_data,
  output logic [3:0]              select,
  output logic                    sel_valid,
  output logic [SPR_BITS-1:0]     spr_x,
  output logic [SPR_BITS-1:0]     spr_y,
  output logic                    scan_busy,
  output logic                    line_overflow,
  output logic                    late_pixel
);

  localparam int unsigned IdxW = $clog2(NUM_OBJ);
  localparam int unsigned CntW = $clog2(MAX_LINE_OBJ + 1);
  localparam int unsigned PosW = $clog2(MAX_LINE_OBJ);
  localparam logic [10:0] SprEdge = 11'(2 ** SPR_BITS);

  typedef enum logic [1:0] {StIdle, StScan, StReady} state_e;

  state_e state_q, state_d;
  logic [IdxW-1:0] cnt_q;
  logic [9:0]      scan_y_q;
  logic            last_slot;

  // Shadow list built during the scan, live list used by the pixel stage.
  logic [MAX_LINE_OBJ-1:0][IdxW-1:0]     sh_idx_q, sh_idx_d, lv_idx_q;
  logic [MAX_LINE_OBJ-1:0][9:0]          sh_x_q, sh_x_d, lv_x_q;
  logic [MAX_LINE_OBJ-1:0][SPR_BITS-1:0] sh_row_q, sh_row_d, lv_row_q;
  logic [MAX_LINE_OBJ-1:0]               sh_vld_q, sh_vld_d, lv_vld_q;
  logic [CntW-1:0]                       sh_cnt_q, sh_cnt_d;
  logic                                  sh_ovf_q, sh_ovf_d;

  logic [9:0] slot_x, slot_y;
  logic       slot_en, slot_hit;

  logic                found;
  logic [IdxW-1:0]     win_idx;
  logic [SPR_BITS-1:0] win_sx, win_row;
  logic                spr_hit;
  logic [3:0]          obj_code, tile_code;

  logic                p_vld_q, p_hit_q;
  logic [3:0]          p_code_q;
  logic [SPR_BITS-1:0] p_sx_q, p_sy_q;

  logic unused_bits;
`ifdef FRIGHTENED_GHOST_EN
  logic [1:0] ghost_off;
  assign ghost_off   = 2'(win_idx - IdxW'(1));
  assign unused_bits = DrawY[9];
`else
  assign unused_bits = ^{DrawY[9], ghost_fright};
`endif

  assign scan_busy = (state_q == StScan);
  assign last_slot = (cnt_q == IdxW'(NUM_OBJ - 1));

  // Next-state: line_start always (re)starts a scan; the last slot hands over to READY.
  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = StScan;
    end else if (state_q == StScan && last_slot) begin
      state_d = StReady;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Select the slot being examined this scan cycle and test it against the scanline.
  always_comb begin
    slot_x  = '0;
    slot_y  = '0;
    slot_en = 1'b0;
    for (int i = 0; i < int'(NUM_OBJ); i++) begin
      if (cnt_q == IdxW'(i)) begin
        slot_x  = obj_x_flat[i*10 +: 10];
        slot_y  = obj_y_flat[i*10 +: 10];
        slot_en = obj_en[i];
      end
    end
    // 11-bit compare so objects near the bottom edge do not wrap.
    slot_hit = slot_en && ({1'b0, slot_y} <= {1'b0, scan_y_q}) &&
               ({1'b0, scan_y_q} < ({1'b0, slot_y} + SprEdge));
  end

  // Append a hit to the shadow list, or flag overflow once it is full.
  always_comb begin
    sh_idx_d = sh_idx_q;
    sh_x_d   = sh_x_q;
    sh_row_d = sh_row_q;
    sh_vld_d = sh_vld_q;
    sh_cnt_d = sh_cnt_q;
    sh_ovf_d = sh_ovf_q;
    if (slot_hit) begin
      if (sh_cnt_q < CntW'(MAX_LINE_OBJ)) begin
        sh_idx_d[sh_cnt_q[PosW-1:0]] = cnt_q;
        sh_x_d[sh_cnt_q[PosW-1:0]]   = slot_x;
        sh_row_d[sh_cnt_q[PosW-1:0]] = scan_y_q[SPR_BITS-1:0] - slot_y[SPR_BITS-1:0];
        sh_vld_d[sh_cnt_q[PosW-1:0]] = 1'b1;
        sh_cnt_d = sh_cnt_q + CntW'(1);
      end else begin
        sh_ovf_d = 1'b1;
      end
    end
  end

  // Scan bookkeeping; the live list is replaced only when a scan runs to completion.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q         <= '0;
      scan_y_q      <= '0;
      sh_idx_q      <= '0;
      sh_x_q        <= '0;
      sh_row_q      <= '0;
      sh_vld_q      <= '0;
      sh_cnt_q      <= '0;
      sh_ovf_q      <= 1'b0;
      lv_idx_q      <= '0;
      lv_x_q        <= '0;
      lv_row_q      <= '0;
      lv_vld_q      <= '0;
      line_overflow <= 1'b0;
    end else if (line_start) begin
      cnt_q    <= '0;
      scan_y_q <= next_y;
      sh_vld_q <= '0;
      sh_cnt_q <= '0;
      sh_ovf_q <= 1'b0;
    end else if (state_q == StScan) begin
      cnt_q    <= cnt_q + IdxW'(1);
      sh_idx_q <= sh_idx_d;
      sh_x_q   <= sh_x_d;
      sh_row_q <= sh_row_d;
      sh_vld_q <= sh_vld_d;
      sh_cnt_q <= sh_cnt_d;
      sh_ovf_q <= sh_ovf_d;
      if (last_slot) begin
        lv_idx_q      <= sh_idx_d;
        lv_x_q        <= sh_x_d;
        lv_row_q      <= sh_row_d;
        lv_vld_q      <= sh_vld_d;
        line_overflow <= sh_ovf_d;
      end
    end
  end

  // Priority resolve: first live entry covering DrawX wins (list is in ascending slot order).
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_sx  = '0;
    win_row = '0;
    for (int j = 0; j < int'(MAX_LINE_OBJ); j++) begin
      if (!found && lv_vld_q[j] && ({1'b0, DrawX} >= {1'b0, lv_x_q[j]}) &&
          ({1'b0, DrawX} < ({1'b0, lv_x_q[j]} + SprEdge))) begin
        found   = 1'b1;
        win_idx = lv_idx_q[j];
        win_sx  = DrawX[SPR_BITS-1:0] - lv_x_q[j][SPR_BITS-1:0];
        win_row = lv_row_q[j];
      end
    end
    // The live list may be stale while a scan is in flight, so sprites are suppressed.
    spr_hit = found && (state_q != StScan);
  end

  // Map the winning slot to its picker code.
  always_comb begin
    obj_code = 4'd7;
    if (win_idx == '0) begin
      obj_code = 4'd5;
    end else if (win_idx == IdxW'(NUM_OBJ - 1)) begin
      obj_code = 4'd3;
`ifdef FRIGHTENED_GHOST_EN
    end else if (ghost_fright[ghost_off]) begin
      obj_code = 4'd4;
`endif
    end
  end

  // Map the tile RAM code to its picker code.
  always_comb begin
    tile_code = 4'd0;
    case (tile_data)
      3'd1:    tile_code = 4'd1;
      3'd2:    tile_code = 4'd2;
      3'd3:    tile_code = 4'd8;
      3'd4:    tile_code = 4'd6;
      default: tile_code = 4'd0;
    endcase
  end

  // Pixel stage 1: issue tile address, register the sprite decision, track late pixels.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      p_vld_q    <= 1'b0;
      p_hit_q    <= 1'b0;
      p_code_q   <= '0;
      p_sx_q     <= '0;
      p_sy_q     <= '0;
      tile_addr  <= '0;
      late_pixel <= 1'b0;
    end else begin
      p_vld_q <= pixel_valid;
      if (pixel_valid) begin
        tile_addr <= {DrawY[8:4], DrawX[8:4]};
        p_hit_q   <= spr_hit;
        p_code_q  <= obj_code;
        p_sx_q    <= spr_hit ? win_sx  : DrawX[SPR_BITS-1:0];
        p_sy_q    <= spr_hit ? win_row : DrawY[SPR_BITS-1:0];
        if (state_q == StScan) late_pixel <= 1'b1;
      end
    end
  end

  // Pixel stage 2: merge with tile_data and present the result.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      select    <= '0;
      sel_valid <= 1'b0;
      spr_x     <= '0;
      spr_y     <= '0;
    end else begin
      sel_valid <= p_vld_q;
      if (p_vld_q) begin
        select <= p_hit_q ? p_code_q : tile_code;
        spr_x  <= p_sx_q;
        spr_y  <= p_sy_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_select_scheduler.sv
// Scoreboard bench for sprite_select_scheduler with a list-based reference model.
module tb_sprite_select_scheduler;
  localparam int NOBJ = 6;

  logic        Clk = 1'b0;
  logic        Reset_n, line_start, pixel_valid;
  logic [9:0]  next_y, DrawX, DrawY, tile_addr;
  logic [59:0] obj_x_flat, obj_y_flat;
  logic [5:0]  obj_en;
  logic [3:0]  ghost_fright, select, spr_x, spr_y;
  logic [2:0]  tile_data;
  logic        sel_valid, scan_busy, line_overflow, late_pixel;

  always #5 Clk = ~Clk;

  sprite_select_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .next_y(next_y),
    .pixel_valid(pixel_valid), .DrawX(DrawX), .DrawY(DrawY), .obj_x_flat(obj_x_flat),
    .obj_y_flat(obj_y_flat), .obj_en(obj_en), .ghost_fright(ghost_fright),
    .tile_addr(tile_addr), .tile_data(tile_data), .select(select), .sel_valid(sel_valid),
    .spr_x(spr_x), .spr_y(spr_y), .scan_busy(scan_busy), .line_overflow(line_overflow),
    .late_pixel(late_pixel)
  );

  typedef struct { int idx; int ox; int row; } ent_t;
  typedef struct { int sel; int sx; int sy; int due; } exp_t;

  ent_t live_m[$];
  exp_t sb[$];
  int   ox[NOBJ], oy[NOBJ];
  bit   en[NOBJ];
  bit [3:0] fr;
  bit   ovf_m, late_m, prev_pv;
  int   scan_left, scan_y_m, prev_addr, pend_tile;
  int   cyc = 0;
  int   nvec = 0, nerr = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  // Reference: list of enabled objects covering the line, ascending slot, at most four.
  function automatic void commit_scan();
    live_m.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < NOBJ; i++) begin
      if (en[i] && oy[i] <= scan_y_m && scan_y_m < oy[i] + 16) begin
        if (live_m.size() < 4) live_m.push_back('{idx: i, ox: ox[i], row: scan_y_m - oy[i]});
        else ovf_m = 1'b1;
      end
    end
  endfunction

  function automatic int obj_code(int idx);
    if (idx == 0) return 5;
    if (idx == 5) return 3;
`ifdef FRIGHTENED_GHOST_EN
    if (fr[idx-1]) return 4;
`endif
    return 7;
  endfunction

  function automatic exp_t ref_pix(int x, int y, int t, bit busy);
    exp_t e;
    if (!busy) begin
      foreach (live_m[k]) begin
        if (x >= live_m[k].ox && x < live_m[k].ox + 16) begin
          e.sel = obj_code(live_m[k].idx);
          e.sx  = x - live_m[k].ox;
          e.sy  = live_m[k].row;
          return e;
        end
      end
    end
    case (t)
      1: e.sel = 1;
      2: e.sel = 2;
      3: e.sel = 8;
      4: e.sel = 6;
      default: e.sel = 0;
    endcase
    e.sx = x % 16;
    e.sy = y % 16;
    return e;
  endfunction

  task automatic apply_objs();
    for (int i = 0; i < NOBJ; i++) begin
      obj_x_flat[i*10 +: 10] = 10'(ox[i]);
      obj_y_flat[i*10 +: 10] = 10'(oy[i]);
      obj_en[i] = en[i];
    end
    ghost_fright = fr;
  endtask

  // One cycle of stimulus, issued at a falling edge; tile_data answers last cycle's pixel.
  task automatic drive(bit ls, int ny, bit pv, int x, int y, int t);
    exp_t e;
    bit busy_now;
    busy_now = (scan_left > 0);
    chk("scan_busy", int'(scan_busy), int'(busy_now));
    chk("line_overflow", int'(line_overflow), int'(ovf_m));
    chk("late_pixel", int'(late_pixel), int'(late_m));
    if (prev_pv) chk("tile_addr", int'(tile_addr), prev_addr);
    tile_data   = 3'(pend_tile);
    line_start  = ls;
    next_y      = 10'(ny);
    pixel_valid = pv;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    if (pv) begin
      e = ref_pix(x, y, t, busy_now);
      e.due = cyc + 2;
      sb.push_back(e);
      if (busy_now) late_m = 1'b1;
    end
    prev_pv   = pv;
    prev_addr = (((y >> 4) & 31) << 5) | ((x >> 4) & 31);
    pend_tile = t;
    if (ls) begin
      scan_left = NOBJ;
      scan_y_m  = ny;
    end else if (scan_left > 0) begin
      scan_left--;
      if (scan_left == 0) commit_scan();
    end
    @(negedge Clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, $urandom_range(0, 1023), 0, $urandom_range(0, 7));
  endtask

  task automatic pix(int x, int y, int t);
    drive(0, 0, 1, x, y, t);
  endtask

  task automatic reset_dut();
    Reset_n     = 1'b0;
    line_start  = 1'b0;
    pixel_valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    live_m.delete();
    sb.delete();
    scan_left = 0;
    ovf_m = 0;
    late_m = 0;
    prev_pv = 0;
    chk("rst_select", int'(select), 0);
    chk("rst_sel_valid", int'(sel_valid), 0);
    chk("rst_spr_x", int'(spr_x), 0);
    chk("rst_spr_y", int'(spr_y), 0);
    chk("rst_tile_addr", int'(tile_addr), 0);
    chk("rst_scan_busy", int'(scan_busy), 0);
    chk("rst_line_overflow", int'(line_overflow), 0);
    chk("rst_late_pixel", int'(late_pixel), 0);
  endtask

  // Monitor: every presented result must match the oldest expectation, on its cycle.
  always @(negedge Clk) begin
    if (sel_valid === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_sel_valid at cycle %0d: got 1 expected 0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sel_latency", cyc, e.due);
        chk("select", int'(select), e.sel);
        chk("spr_x", int'(spr_x), e.sx);
        chk("spr_y", int'(spr_y), e.sy);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    Reset_n = 1'b0; line_start = 1'b0; pixel_valid = 1'b0; next_y = '0;
    DrawX = '0; DrawY = '0; tile_data = '0;
    for (int i = 0; i < NOBJ; i++) begin ox[i] = 0; oy[i] = 0; en[i] = 0; end
    fr = '0;
    apply_objs();
    repeat (2) @(negedge Clk);
    reset_dut();

    // Tile-only pixels.
    pix(33, 20, 3); pix(40, 21, 4); pix(50, 22, 7); pix(60, 23, 1);
    idle(3);

    // Pac-Man and ghost 1 on line 55.
    ox[0] = 100; oy[0] = 50; en[0] = 1;
    ox[1] = 104; oy[1] = 50; en[1] = 1;
    apply_objs();
    drive(1, 55, 0, 0, 0, 0); idle(7);
    pix(106, 55, 0); pix(117, 55, 3); pix(99, 55, 2); pix(120, 55, 4);
    idle(3);

    // Frightened ghost 2.
    ox[2] = 200; oy[2] = 60; en[2] = 1; fr = 4'b0010;
    apply_objs();
    drive(1, 61, 0, 0, 0, 0); idle(7);
    pix(205, 61, 0); pix(106, 61, 0);
    idle(3);

    // All six slots on line 10: overflow, fruit dropped.
    for (int i = 0; i < NOBJ; i++) begin ox[i] = 300 + 20 * i; oy[i] = 10; en[i] = 1; end
    apply_objs();
    drive(1, 10, 0, 0, 0, 0); idle(7);
    for (int i = 0; i < NOBJ; i++) pix(ox[i] + 3, 10, 1);
    idle(3);

    // Restart mid-scan: second next_y wins.
    for (int i = 0; i < NOBJ; i++) en[i] = 0;
    ox[0] = 450; oy[0] = 100; en[0] = 1;
    ox[3] = 400; oy[3] = 200; en[3] = 1;
    apply_objs();
    drive(1, 100, 0, 0, 0, 0); idle(2);
    drive(1, 200, 0, 0, 0, 0); idle(8);
    pix(405, 200, 0); pix(455, 200, 2);
    idle(3);

    // Pixel during scan: tile only, late_pixel sticks.
    drive(1, 200, 0, 0, 0, 0); idle(1);
    pix(405, 200, 2);
    idle(7);
    pix(405, 200, 2);
    idle(3);

    // Reset mid-scan empties the live list.
    drive(1, 200, 0, 0, 0, 0); idle(2);
    reset_dut();
    pix(405, 200, 3);
    idle(3);

    // Randomised rounds.
    for (int r = 0; r < 30; r++) begin
      while (scan_left > 0) idle(1);
      base = $urandom_range(20, 400);
      for (int i = 0; i < NOBJ; i++) begin
        ox[i] = 100 + $urandom_range(0, 60);
        oy[i] = base + $urandom_range(0, 30) - 20;
        en[i] = ($urandom % 4) != 0;
      end
      fr = 4'($urandom);
      apply_objs();
      drive(1, base, 0, 0, 0, 0);
      for (int p = 0; p < 25; p++) begin
        int i;
        i = $urandom % NOBJ;
        drive(($urandom % 20) == 0, base + $urandom_range(0, 3), ($urandom % 10) < 7,
              ox[i] + $urandom_range(0, 19) - 2, $urandom_range(0, 1023), $urandom_range(0, 7));
      end
    end

    idle(8);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
